// File: rtl/nes_mapper_pkg.sv
// ============================================================================
// Module : nes_mapper_pkg
// Brief  : Shared board enumeration and register reset constants for MMC1 mappers
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nes_mapper_pkg;

  typedef enum logic [2:0] {
    BOARD_SKROM = 3'd0,
    BOARD_SNROM = 3'd1,
    BOARD_SOROM = 3'd2,
    BOARD_SUROM = 3'd3,
    BOARD_SXROM = 3'd4
  } board_t;

  localparam logic [4:0] c_shift_empty  = 5'b10000;
  localparam logic [4:0] c_ctrl_reset   = 5'b01100;
  localparam logic [4:0] c_ctrl_set_or  = 5'b01100;

  localparam logic [1:0] c_tgt_control  = 2'd0;
  localparam logic [1:0] c_tgt_chr0     = 2'd1;
  localparam logic [1:0] c_tgt_chr1     = 2'd2;
  localparam logic [1:0] c_tgt_prg      = 2'd3;

endpackage

`default_nettype wire

// File: rtl/mmc1_serial_loader.sv
// ============================================================================
// Module : mmc1_serial_loader
// Brief  : MMC1 write filter and 5-bit serial shift register with load strobe
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmc1_serial_loader
  import nes_mapper_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ce_i,
  input  logic       write_i,
  input  logic       addr15_i,
  input  logic [1:0] addr_sel_i,
  input  logic       din7_i,
  input  logic       din0_i,
  output logic       clear_o,
  output logic       load_o,
  output logic [1:0] target_o,
  output logic [4:0] data_o
);

  logic [4:0] shift_q, shift_d;
  logic       filter_q, filter_d;
  logic       w_qual;
  logic       w_accept;

  assign w_qual   = write_i & addr15_i;
  assign w_accept = ce_i & w_qual & ~filter_q;

  // The marker bit reaching position 0 means four bits are held; this write completes the word.
  always_comb begin
    shift_d  = shift_q;
    filter_d = filter_q;
    clear_o  = 1'b0;
    load_o   = 1'b0;
    target_o = addr_sel_i;
    data_o   = {din0_i, shift_q[4:1]};
    if (ce_i) begin
      filter_d = w_qual;
    end
    if (w_accept) begin
      if (din7_i) begin
        clear_o = 1'b1;
        shift_d = c_shift_empty;
      end else if (shift_q[0]) begin
        load_o  = 1'b1;
        shift_d = c_shift_empty;
      end else begin
        shift_d = {din0_i, shift_q[4:1]};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q  <= c_shift_empty;
      filter_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      filter_q <= filter_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sxrom_mapper.sv
// ============================================================================
// Module : sxrom_mapper
// Brief  : MMC1 (SxROM family) PRG/CHR banking, mirroring and PRG RAM control
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sxrom_mapper
  import nes_mapper_pkg::*;
#(
  parameter board_t BOARD      = BOARD_SKROM,
  parameter bit     MMC1A      = 1'b0,
  parameter int     PRG_ROM_KB = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] prg_ain,
  input  logic        prg_write,
  input  logic [7:0]  prg_din,
  input  logic [13:0] chr_ain,
  output logic [21:0] prg_aout,
  output logic        prg_allow,
  output logic [21:0] chr_aout,
  output logic        vram_a10,
  output logic        vram_ce,
  output logic        wram_en
);

  localparam int          c_prg_aw_raw = $clog2(PRG_ROM_KB) + 10;
  localparam int          c_prg_aw     = (c_prg_aw_raw < 15) ? 15 :
                                         (c_prg_aw_raw > 19) ? 19 : c_prg_aw_raw;
  localparam logic [18:0] c_prg_mask   = 19'((20'd1 << c_prg_aw) - 20'd1);

  logic [4:0]  control_q, control_d;
  logic [4:0]  chr0_q, chr0_d;
  logic [4:0]  chr1_q, chr1_d;
  logic [4:0]  prg_q, prg_d;

  logic        w_clear;
  logic        w_load;
  logic [1:0]  w_target;
  logic [4:0]  w_data;
  logic [4:0]  w_csel;
  logic [3:0]  w_bank;
  logic        w_a18;
  logic [18:0] w_rom_addr;
  logic [1:0]  w_ram_bank;
  logic        w_wram_en;
  logic        w_unused_din;

  assign w_unused_din = ^prg_din[6:1];

  mmc1_serial_loader u_loader (
    .clk_i      (clk),
    .rst_i      (reset),
    .ce_i       (ce),
    .write_i    (prg_write),
    .addr15_i   (prg_ain[15]),
    .addr_sel_i (prg_ain[14:13]),
    .din7_i     (prg_din[7]),
    .din0_i     (prg_din[0]),
    .clear_o    (w_clear),
    .load_o     (w_load),
    .target_o   (w_target),
    .data_o     (w_data)
  );

  always_comb begin
    control_d = control_q;
    chr0_d    = chr0_q;
    chr1_d    = chr1_q;
    prg_d     = prg_q;
    if (w_clear) begin
      control_d = control_q | c_ctrl_set_or;
    end
    if (w_load) begin
      case (w_target)
        c_tgt_control: control_d = w_data;
        c_tgt_chr0:    chr0_d    = w_data;
        c_tgt_chr1:    chr1_d    = w_data;
        default:       prg_d     = w_data;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      control_q <= c_ctrl_reset;
      chr0_q    <= 5'd0;
      chr1_q    <= 5'd0;
      prg_q     <= 5'd0;
    end else begin
      control_q <= control_d;
      chr0_q    <= chr0_d;
      chr1_q    <= chr1_d;
      prg_q     <= prg_d;
    end
  end

  assign w_csel = control_q[4] ? (chr_ain[12] ? chr1_q : chr0_q)
                               : {chr0_q[4:1], chr_ain[12]};

  // MMC1A feeds prg[3] straight to the bank MSB so the fixed bank stays in the selected half.
  always_comb begin
    case (control_q[3:2])
      2'b10:   w_bank = prg_ain[14] ? prg_q[3:0] : 4'h0;
      2'b11:   w_bank = prg_ain[14] ? 4'hF : prg_q[3:0];
      default: w_bank = {prg_q[3:1], prg_ain[14]};
    endcase
    if (MMC1A) begin
      w_bank[3] = prg_q[3];
    end
  end

  assign w_a18      = ((BOARD == BOARD_SUROM) || (BOARD == BOARD_SXROM)) ? w_csel[4] : 1'b0;
  assign w_rom_addr = {w_a18, w_bank, prg_ain[13:0]} & c_prg_mask;

  always_comb begin
    w_ram_bank = 2'b00;
    if (BOARD == BOARD_SOROM) begin
      w_ram_bank = {1'b0, w_csel[3]};
    end else if (BOARD == BOARD_SXROM) begin
      w_ram_bank = w_csel[3:2];
    end
  end

  assign w_wram_en = (MMC1A || !prg_q[4]) && !((BOARD == BOARD_SNROM) && w_csel[4]);

  assign prg_aout  = prg_ain[15] ? {3'b000, w_rom_addr}
                                 : {7'b1111000, w_ram_bank, prg_ain[12:0]};
  assign prg_allow = (prg_ain[15] && !prg_write) || ((prg_ain[15:13] == 3'b011) && w_wram_en);
  assign wram_en   = w_wram_en;
  assign chr_aout  = {5'b10000, w_csel, chr_ain[11:0]};
  assign vram_ce   = chr_ain[13];

  always_comb begin
    case (control_q[1:0])
      2'b00:   vram_a10 = 1'b0;
      2'b01:   vram_a10 = 1'b1;
      2'b10:   vram_a10 = chr_ain[10];
      default: vram_a10 = chr_ain[11];
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_sxrom_mapper.sv
// ============================================================================
// Module : tb_sxrom_mapper
// Brief  : Self-checking bench for sxrom_mapper across all board wirings
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sxrom_mapper;
  import nes_mapper_pkg::*;

  localparam int c_n = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ce = 1'b0;
  logic        prg_write = 1'b0;
  logic [15:0] prg_ain = 16'h8000;
  logic [7:0]  prg_din = 8'h00;
  logic [13:0] chr_ain = 14'h0;

  logic [21:0] o_pa    [c_n];
  logic [21:0] o_ca    [c_n];
  logic        o_allow [c_n];
  logic        o_a10   [c_n];
  logic        o_vce   [c_n];
  logic        o_wen   [c_n];

  int chk_cnt = 0;
  int err_cnt = 0;

  int m_ctrl, m_chr0, m_chr1, m_prg, m_cnt, m_val;
  bit m_last;

  always #5 clk = ~clk;

  function automatic board_t f_board(input int g);
    case (g)
      1:       return BOARD_SNROM;
      2:       return BOARD_SOROM;
      3:       return BOARD_SUROM;
      4:       return BOARD_SXROM;
      default: return BOARD_SKROM;
    endcase
  endfunction

  function automatic int f_kb(input int g);
    if (g == 3 || g == 4) return 512;
    if (g == 5) return 128;
    return 256;
  endfunction

  for (genvar g = 0; g < c_n; g++) begin : g_dut
    sxrom_mapper #(
      .BOARD      (f_board(g)),
      .MMC1A      (g == 5),
      .PRG_ROM_KB (f_kb(g))
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .ce        (ce),
      .prg_ain   (prg_ain),
      .prg_write (prg_write),
      .prg_din   (prg_din),
      .chr_ain   (chr_ain),
      .prg_aout  (o_pa[g]),
      .prg_allow (o_allow[g]),
      .chr_aout  (o_ca[g]),
      .vram_a10  (o_a10[g]),
      .vram_ce   (o_vce[g]),
      .wram_en   (o_wen[g])
    );
  end

  task automatic t_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_ctrl = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0;
    m_cnt = 0; m_val = 0; m_last = 1'b0;
  endfunction

  function automatic void model_update(input bit w, input int a, input int d);
    bit   qual;
    int   v;
    qual = w && (a >= 32768);
    if (qual && !m_last) begin
      if (d >= 128) begin
        m_cnt = 0; m_val = 0; m_ctrl = m_ctrl | 12;
      end else if (m_cnt == 4) begin
        v = m_val + (d % 2) * 16;
        case ((a / 8192) % 4)
          0:       m_ctrl = v;
          1:       m_chr0 = v;
          2:       m_chr1 = v;
          default: m_prg  = v;
        endcase
        m_cnt = 0; m_val = 0;
      end else begin
        m_val = m_val + (d % 2) * (2 ** m_cnt);
        m_cnt = m_cnt + 1;
      end
    end
    m_last = qual;
  endfunction

  function automatic void model_eval(input int b, input bit mmc1a, input int kb,
                                     output int pa, output bit al, output int ca,
                                     output bit a10, output bit vce, output bit wen);
    int a, c, csel, mode, bank, hi, rom, rb;
    a = int'(prg_ain);
    c = int'(chr_ain);
    if (m_ctrl >= 16) csel = ((c / 4096) % 2 == 1) ? m_chr1 : m_chr0;
    else              csel = (m_chr0 / 2) * 2 + (c / 4096) % 2;
    mode = (m_ctrl / 4) % 4;
    if (mode < 2)       bank = (m_prg % 16) / 2 * 2 + (a / 16384) % 2;
    else if (mode == 2) bank = ((a / 16384) % 2 == 1) ? m_prg % 16 : 0;
    else                bank = ((a / 16384) % 2 == 1) ? 15 : m_prg % 16;
    if (mmc1a) bank = bank % 8 + ((m_prg / 8) % 2) * 8;
    hi  = (b == 3 || b == 4) ? csel / 16 : 0;
    rom = (hi * 262144 + bank * 16384 + a % 16384) % (kb * 1024);
    wen = (mmc1a || m_prg < 16) && !(b == 1 && csel >= 16);
    rb  = (b == 2) ? (csel / 8) % 2 : (b == 4) ? (csel / 4) % 4 : 0;
    pa  = (a >= 32768) ? rom : 32'h3C0000 + rb * 8192 + a % 8192;
    al  = (a >= 32768 && !prg_write) || (a >= 24576 && a < 32768 && wen);
    ca  = 32'h200000 + csel * 4096 + c % 4096;
    case (m_ctrl % 4)
      0:       a10 = 1'b0;
      1:       a10 = 1'b1;
      2:       a10 = (c / 1024) % 2 == 1;
      default: a10 = (c / 2048) % 2 == 1;
    endcase
    vce = c >= 8192;
  endfunction

  task automatic check_all();
    int pa, ca;
    bit al, a10, vce, wen;
    for (int g = 0; g < c_n; g++) begin
      model_eval(int'(f_board(g)), g == 5, f_kb(g), pa, al, ca, a10, vce, wen);
      if (prg_ain >= 16'h6000)
        t_check($sformatf("prg_aout[%0d] a=%h", g, prg_ain), 32'(o_pa[g]), pa);
      t_check($sformatf("prg_allow[%0d] a=%h", g, prg_ain), 32'(o_allow[g]), 32'(al));
      t_check($sformatf("chr_aout[%0d] c=%h", g, chr_ain), 32'(o_ca[g]), ca);
      t_check($sformatf("vram_a10[%0d]", g), 32'(o_a10[g]), 32'(a10));
      t_check($sformatf("vram_ce[%0d]", g), 32'(o_vce[g]), 32'(vce));
      t_check($sformatf("wram_en[%0d]", g), 32'(o_wen[g]), 32'(wen));
    end
  endtask

  task automatic step(input bit c, input bit w, input logic [15:0] a,
                      input logic [7:0] d, input logic [13:0] ch);
    ce = c; prg_write = w; prg_ain = a; prg_din = d; chr_ain = ch;
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (c) model_update(w, int'(a), int'(d));
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    step(1'b1, 1'b1, a, d, 14'h0);
    step(1'b1, 1'b0, 16'h8000, 8'h00, 14'h0);
  endtask

  task automatic wr5(input logic [15:0] a, input logic [4:0] v);
    for (int k = 0; k < 5; k++) wr(a, {7'd0, v[k]});
  endtask

  task automatic read_at(input logic [15:0] a);
    ce = 1'b0; prg_write = 1'b0; prg_ain = a; chr_ain = 14'h0;
    #1;
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rd;
    model_reset();
    #1 reset = 1'b1;
    #1;
    check_all();
    t_check("rst_pa_8000", 32'(o_pa[0]), 32'h0);
    read_at(16'hC000);
    t_check("rst_pa_C000_256k", 32'(o_pa[0]), 32'h3C000);
    t_check("rst_pa_C000_mmc1a_128k", 32'(o_pa[5]), 32'h1C000);
    t_check("rst_wen", 32'(o_wen[0]), 32'h1);
    @(negedge clk) reset = 1'b0;
    @(posedge clk) #1;

    wr5(16'hE000, 5'b01101);
    read_at(16'h8000);
    t_check("load_prg_bank_D", 32'(o_pa[0][17:14]), 32'hD);

    step(1'b1, 1'b1, 16'hE000, 8'h00, 14'h0);
    step(1'b1, 1'b1, 16'hE000, 8'h01, 14'h0);
    step(1'b1, 1'b0, 16'h8000, 8'h00, 14'h0);
    wr(16'hE000, 8'h01); wr(16'hE000, 8'h00); wr(16'hE000, 8'h00); wr(16'hE000, 8'h00);
    read_at(16'h8000);
    t_check("rmw_single_shift", 32'(o_pa[0][17:14]), 32'h2);

    wr5(16'h8000, 5'b10001);
    wr(16'hE000, 8'h01); wr(16'hE000, 8'h01); wr(16'hE000, 8'h01);
    wr(16'h8000, 8'h80);
    t_check("clear_ctrl_a10", 32'(o_a10[0]), 32'h1);
    read_at(16'hC000);
    t_check("clear_ctrl_mode3", 32'(o_pa[0]), 32'h3C000);
    wr5(16'hE000, 5'b00101);
    read_at(16'h8000);
    t_check("after_clear_load", 32'(o_pa[0][17:14]), 32'h5);

    wr5(16'hA000, 5'h10);
    read_at(16'hC000);
    t_check("surom_fixed_hi", 32'(o_pa[3]), 32'h7C000);
    t_check("sxrom_fixed_hi", 32'(o_pa[4]), 32'h7C000);
    t_check("skrom_fixed", 32'(o_pa[0]), 32'h3C000);
    read_at(16'h6000);
    t_check("snrom_wen", 32'(o_wen[1]), 32'h0);
    t_check("snrom_allow", 32'(o_allow[1]), 32'h0);
    t_check("skrom_allow", 32'(o_allow[0]), 32'h1);

    wr(16'hE000, 8'h01); wr(16'hE000, 8'h01);
    reset = 1'b1;
    model_reset();
    read_at(16'hC000);
    t_check("async_rst_surom", 32'(o_pa[3]), 32'h3C000);
    t_check("async_rst_snrom_wen", 32'(o_wen[1]), 32'h1);
    check_all();
    @(negedge clk) reset = 1'b0;
    @(posedge clk) #1;
    wr5(16'hE000, 5'b00011);
    read_at(16'h8000);
    t_check("fresh_seq_after_rst", 32'(o_pa[0][17:14]), 32'h3);

    for (int i = 0; i < 3000; i++) begin
      ra = 16'($urandom);
      if ($urandom_range(0, 9) < 6) ra[15] = 1'b1;
      rd = 8'($urandom);
      if ($urandom_range(0, 15) != 0) rd[7] = 1'b0;
      step($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4, ra, rd, 14'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire
